fp_mul_sched: RTL and testbench

//  Schedules one shared single-precision multiply datapath between two requesters.
//  The datapath is a fixed-latency 24x24 mantissa multiplier plus the Normalize stage (mul_out -> fraction_out, ecout).

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 16 +
 rtl/fp_mul_sched.sv | 179 +++++++++++++++++
 tb/tb_fp_mul_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - IEEE single field widths, slice positions and multiply-scheduler state encoding
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int PROD_W   = 48;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Restore the hidden leading one; denormals never reach the multiplier.
  function automatic logic [MANT_W-1:0] mant_of(input logic [31:0] f);
    return {1'b1, f[FRAC_HI:0]};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, purely combinational
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // ptr only matters on contention; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// rtl/fp_mul_sched.sv - shares one mantissa multiplier + Normalize between two single-precision requesters
module fp_mul_sched #(
  parameter int MUL_LAT  = 3,
  parameter int EXP_BIAS = fpu_pkg::EXP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        mul_start,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  input  logic [47:0] mul_p,
  output logic [47:0] norm_in,
  input  logic [22:0] norm_frac,
  input  logic        norm_ecout
);
  import fpu_pkg::*;

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                owner_q, owner_d;
  logic                sign_q, sign_d;
  logic                byp_q, byp_d;
  logic [EXP_W-1:0]    exp_a_q, exp_a_d;
  logic [EXP_W-1:0]    exp_b_q, exp_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mul_start_q, mul_start_d;
  logic [MANT_W-1:0]   mul_a_q, mul_a_d;
  logic [MANT_W-1:0]   mul_b_q, mul_b_d;
  logic [PROD_W-1:0]   norm_in_q, norm_in_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;

  logic [1:0]          gnt;
  logic [31:0]         sel_a, sel_b;
  logic [EXP_W-1:0]    sel_exp_a, sel_exp_b;
  logic [9:0]          exp_raw;
  logic signed [9:0]   exp_sum;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign sel_a     = gnt[1] ? req_a1 : req_a0;
  assign sel_b     = gnt[1] ? req_b1 : req_b0;
  assign sel_exp_a = sel_a[EXP_HI:EXP_LO];
  assign sel_exp_b = sel_b[EXP_HI:EXP_LO];

  // Two zero-extension bits keep the biased sum and its sign in range for any exponent pair.
  assign exp_raw = {2'b00, exp_a_q} + {2'b00, exp_b_q} + {9'd0, norm_ecout} - 10'(EXP_BIAS);
  assign exp_sum = $signed(exp_raw);

  assign req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign norm_in   = norm_in_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    sign_d      = sign_q;
    byp_d       = byp_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    cnt_d       = cnt_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    norm_in_d   = norm_in_q;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d  = gnt[1];
          rr_ptr_d = ~gnt[1];
          sign_d   = sel_a[SIGN_BIT] ^ sel_b[SIGN_BIT];
          exp_a_d  = sel_exp_a;
          exp_b_d  = sel_exp_b;
          byp_d    = (sel_exp_a == '0) || (sel_exp_b == '0);
          // A flushed operand spends one NORM cycle idle so the multiplier is never launched.
          if ((sel_exp_a == '0) || (sel_exp_b == '0)) begin
            state_d = ST_NORM;
          end else begin
            mul_a_d     = mant_of(sel_a);
            mul_b_d     = mant_of(sel_b);
            mul_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_MUL;
          end
        end
      end

      ST_MUL: begin
        if (cnt_q == CNT_W'(MUL_LAT)) begin
          norm_in_d = mul_p;
          state_d   = ST_NORM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_NORM: begin
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        if (byp_q || (exp_sum <= 10'sd0)) begin
          rsp_data_d = {sign_q, 31'd0};
        end else if (exp_sum >= 10'sd255) begin
          rsp_data_d = {sign_q, 8'hFF, 23'd0};
        end else begin
          rsp_data_d = {sign_q, exp_sum[EXP_W-1:0], norm_frac};
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      sign_q      <= 1'b0;
      byp_q       <= 1'b0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      norm_in_q   <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      sign_q      <= sign_d;
      byp_q       <= byp_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      cnt_q       <= cnt_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      norm_in_q   <= norm_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Unused package widths are referenced here only through FRAC_W to keep the Normalize port tied to it.
  logic unused_frac_w;
  assign unused_frac_w = (FRAC_W == 23) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb/tb_fp_mul_sched.sv - directed and randomized checks of fp_mul_sched against a behavioural model
module tb_fp_mul_sched;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        mul_start;
  logic [23:0] mul_a, mul_b;
  logic [47:0] mul_p;
  logic [47:0] norm_in;
  logic [22:0] norm_frac;
  logic        norm_ecout;

  always #5 clk = ~clk;

  fp_mul_sched #(.MUL_LAT(MUL_LAT), .EXP_BIAS(127)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .norm_in    (norm_in),
    .norm_frac  (norm_frac),
    .norm_ecout (norm_ecout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // IEEE single multiply with truncating normalisation, zero/denormal flush, overflow to infinity.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic        s;
    logic [47:0] p;
    logic [22:0] f;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 0 || eb == 0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127 + (p[47] ? 1 : 0);
    f = p[47] ? p[46:24] : p[45:23];
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(58, 68));
      3:       e = 8'($urandom_range(190, 198));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // External multiplier: product is valid only in the cycle MUL_LAT after mul_start, junk otherwise.
  logic [47:0] prod_m, junk;
  logic [23:0] la, lb;
  int          rem;
  bit          act;

  always @(posedge clk) junk <= 48'({$urandom, $urandom});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 1'b0;
      rem <= 0;
    end else if (mul_start) begin
      act    <= 1'b1;
      rem    <= MUL_LAT - 1;
      prod_m <= 48'(mul_a) * 48'(mul_b);
      la     <= mul_a;
      lb     <= mul_b;
    end else if (act) begin
      if (rem == 0) act <= 1'b0;
      else rem <= rem - 1;
    end
  end

  assign mul_p      = (act && rem == 0) ? prod_m : junk;
  assign norm_ecout = norm_in[47];
  assign norm_frac  = norm_in[47] ? norm_in[46:24] : norm_in[45:23];

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int          cyc = 0;
  bit          busy = 1'b0;
  bit          exp_ptr = 1'b0;
  int          mul_starts = 0;
  int          rsp_count = 0;
  logic [31:0] last_rsp = '0;
  logic        mwho;
  logic [31:0] ma, mb;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      busy    = 1'b0;
      exp_ptr = 1'b0;
    end else begin
      if (mul_start) mul_starts++;
      if (act) begin
        chk("mul_a_hold", 64'(mul_a), 64'(la));
        chk("mul_b_hold", 64'(mul_b), 64'(lb));
      end
      if (!busy) begin
        if (req_valid != 2'b00) begin
          mwho = (req_valid == 2'b11) ? exp_ptr : req_valid[1];
          chk("grant", 64'(req_ready), 64'(mwho ? 2'b10 : 2'b01));
          ma        = mwho ? req_a1 : req_a0;
          mb        = mwho ? req_b1 : req_b0;
          e_m.owner = mwho;
          e_m.data  = ref_mul(ma, mb);
          e_m.cyc   = cyc;
          e_m.lat   = (ma[30:23] == 8'd0 || mb[30:23] == 8'd0) ? 2 : MUL_LAT + 3;
          sb.push_back(e_m);
          busy    = 1'b1;
          exp_ptr = ~mwho;
        end else begin
          chk("ready_idle", 64'(req_ready), 64'(0));
        end
      end else if (req_valid != 2'b00) begin
        chk("ready_busy", 64'(req_ready), 64'(0));
      end
      if (rsp_valid != 2'b00) begin
        rsp_count++;
        last_rsp = rsp_data;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e_m = sb.pop_front();
          chk("rsp_owner", 64'(rsp_valid), 64'(e_m.owner ? 2'b10 : 2'b01));
          chk("rsp_data", 64'(rsp_data), 64'(e_m.data));
          chk("rsp_latency", 64'(cyc - e_m.cyc), 64'(e_m.lat));
        end
        busy = 1'b0;
      end else if (sb.size() != 0 && (cyc - sb[0].cyc) > sb[0].lat) begin
        chk("rsp_timeout", 64'(cyc - sb[0].cyc), 64'(sb[0].lat));
        void'(sb.pop_front());
        busy = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic op(input int who, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (who == 0) begin
      req_a0 = a;
      req_b0 = b;
    end else begin
      req_a1 = a;
      req_b1 = b;
    end
    req_valid[who] = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      got = req_ready[who];
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("op_granted", 64'(got), 64'(1));
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_mul_start"}, 64'(mul_start), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_mul_a"}, 64'(mul_a), 64'(0));
    chk({tag, "_mul_b"}, 64'(mul_b), 64'(0));
    chk({tag, "_norm_in"}, 64'(norm_in), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int   ms, rc, gcount;
  logic owners[4];

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a0    = '0;
    req_b0    = '0;
    req_a1    = '0;
    req_b1    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 32'h40000000, 32'h40400000);
    chk("t1_2x3", 64'(last_rsp), 64'(32'h40C00000));

    ms = mul_starts;
    op(0, 32'h00000000, 32'h3F800000);
    chk("t3_zero", 64'(last_rsp), 64'(32'h00000000));
    chk("t3_no_mul_start", 64'(mul_starts), 64'(ms));

    op(0, 32'h00800000, 32'h00800000);
    chk("t5_flush", 64'(last_rsp), 64'(32'h00000000));

    op(1, 32'hC0000000, 32'h40400000);
    chk("t_neg", 64'(last_rsp), 64'(32'hC0C00000));

    op(1, 32'h7F000000, 32'h40000000);
    chk("t4_inf", 64'(last_rsp), 64'(32'h7F800000));

    // Both requesters hold valid; the last grant went to 1, so 0 wins first.
    @(negedge clk);
    req_a0    = rand_fp();
    req_b0    = rand_fp();
    req_a1    = rand_fp();
    req_b1    = rand_fp();
    req_valid = 2'b11;
    gcount    = 0;
    for (int i = 0; i < 80 && gcount < 4; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        owners[gcount] = req_ready[1];
        gcount++;
        @(negedge clk);
        if (owners[gcount-1]) begin
          req_a1 = rand_fp();
          req_b1 = rand_fp();
        end else begin
          req_a0 = rand_fp();
          req_b0 = rand_fp();
        end
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 2'b00;
    chk("t2_grants", 64'(gcount), 64'(4));
    chk("t2_g0", 64'(owners[0]), 64'(0));
    chk("t2_g1", 64'(owners[1]), 64'(1));
    chk("t2_g2", 64'(owners[2]), 64'(0));
    chk("t2_g3", 64'(owners[3]), 64'(1));
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_valid = 2'($urandom);
      req_a0    = rand_fp();
      req_b0    = rand_fp();
      req_a1    = rand_fp();
      req_b1    = rand_fp();
    end
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle();

    // Reset in the middle of a multiply aborts it without a response.
    rc = rsp_count;
    @(negedge clk);
    req_a0    = 32'h40000000;
    req_b0    = 32'h40400000;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    chk("t6_granted", 64'(busy), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_abort");
    repeat (3) @(negedge clk);
    chk("t6_no_rsp", 64'(rsp_count), 64'(rc));
    rst_n = 1'b1;
    op(0, 32'h3FC00000, 32'h40000000);
    chk("t6_after_reset", 64'(last_rsp), 64'(32'h40400000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
